// File: rtl/logic_unit_pipe_pkg.sv
// rtl/logic_unit_pipe_pkg.sv - shared ALU opcode encoding for the bitwise logic unit
package logic_unit_pipe_pkg;

  localparam int LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND   = 3'd0,
    LU_OR    = 3'd1,
    LU_XOR   = 3'd2,
    LU_NAND  = 3'd3,
    LU_NOR   = 3'd4,
    LU_XNOR  = 3'd5,
    LU_ANDN  = 3'd6,
    LU_PASSA = 3'd7
  } lu_op_e;

endpackage

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational bitwise opcode mux, reusable by unregistered ALU paths
module logic_unit_core
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [LU_OP_W-1:0] op_i,
  output logic [WIDTH-1:0]   result_o
);

  // Select one of eight per-bit operations; PASSA ignores B entirely
  always_comb begin
    result_o = '0;
    case (lu_op_e'(op_i))
      LU_AND:   result_o = a_i & b_i;
      LU_OR:    result_o = a_i | b_i;
      LU_XOR:   result_o = a_i ^ b_i;
      LU_NAND:  result_o = ~(a_i & b_i);
      LU_NOR:   result_o = ~(a_i | b_i);
      LU_XNOR:  result_o = ~(a_i ^ b_i);
      LU_ANDN:  result_o = a_i & ~b_i;
      LU_PASSA: result_o = a_i;
      default:  result_o = a_i;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered bitwise logic unit with valid/ready handshake and accumulator
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit ACC_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [LU_OP_W-1:0] in_op,
  input  logic               use_acc,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_zero,
  output logic               out_ones,
  output logic               out_parity,
  output logic [WIDTH-1:0]   acc_q
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             parity_q, parity_d;

  logic             accept;
  logic [WIDTH-1:0] acc_cur;
  logic [WIDTH-1:0] acc_operand;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] core_result;

  // The slot frees up whenever it is empty or being drained this cycle
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A clear arriving with an accept is applied before the operand is taken
  assign acc_operand = acc_clr ? '0 : acc_cur;
  assign b_eff       = (ACC_EN && use_acc) ? acc_operand : in_b;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i      (in_a),
    .b_i      (b_eff),
    .op_i     (in_op),
    .result_o (core_result)
  );

  // Output slot next state: load on accept, drop valid on drain, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    parity_d    = parity_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_result;
      zero_d      = ~|core_result;
      ones_d      = &core_result;
      parity_d    = ^core_result;
    end else if (out_ready) begin
      // Drained: result and flags keep their last value on purpose
      out_valid_d = 1'b0;
    end
  end

  // Output slot register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      parity_q    <= parity_d;
    end
  end

  generate
    if (ACC_EN) begin : g_acc
      logic [WIDTH-1:0] acc_val_q, acc_val_d;

      // Accumulator tracks every accepted result; a lone clear zeroes it regardless of backpressure
      always_comb begin
        acc_val_d = acc_val_q;
        if (accept) begin
          acc_val_d = core_result;
        end else if (acc_clr) begin
          acc_val_d = '0;
        end
      end

      // Accumulator register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_val_q <= '0;
        end else begin
          acc_val_q <= acc_val_d;
        end
      end

      assign acc_cur = acc_val_q;
    end else begin : g_no_acc
      assign acc_cur = '0;
    end
  endgenerate

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_ones   = ones_q;
  assign out_parity = parity_q;
  assign acc_q      = acc_cur;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's fixed 4-bit bitwise AND unit.
- Performs one of eight bitwise operations on WIDTH-bit operands and produces result flags.
- Optional accumulator chaining: the previous result can replace operand B.
- Valid/ready handshake on both sides, one pipeline register, so it sits directly in the ALU datapath between operand fetch and writeback.

Parameters:
- WIDTH, 4, operand/result width in bits (>=1).
- ACC_EN, 1, 1 = accumulator and use_acc path present; 0 = use_acc ignored, acc tied to 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B (ignored when use_acc=1 and ACC_EN=1).
- in_op  in  3  opcode (see Behaviour).
- use_acc  in  1  take B from accumulator.
- acc_clr  in  1  synchronous accumulator clear, independent of handshake.
- out_valid  out  1  result register holds valid data.
- out_ready  in  1  downstream accepts.
- out_result  out  WIDTH  registered result.
- out_zero  out  1  result == 0.
- out_ones  out  1  result == all ones.
- out_parity  out  1  XOR-reduction of result.
- acc_q  out  WIDTH  current accumulator value.

Behaviour:
- Reset (async assert, sync-safe deassert by upstream):
  - out_valid=0, out_result=0, out_zero=0, out_ones=0, out_parity=0, acc_q=0.
  - in_ready=1 after reset.
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (A & ~B), 7 PASSA (B unused). All bitwise per bit, no carry, width WIDTH.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept: the result register and flags load next edge, and out_valid=1. Latency 1 cycle. Full throughput 1/cycle while out_ready=1.
  - out_valid && !out_ready: result, flags and out_valid hold stable. in_ready=0, so no input is consumed.
  - out_valid && out_ready && no accept: out_valid->0. out_result holds its last value; do not clear it.
  - Simultaneous output drain and accept: the new result replaces the old one in the same edge, with no bubble.
- Operand B select: B_eff = (ACC_EN && use_acc) ? acc_next_operand : in_b.
- Accumulator (ACC_EN=1):
  - On accept, acc <= result of that transaction, regardless of use_acc.
  - acc_clr=1 with no accept: acc <= 0.
  - acc_clr=1 with an accept: the clear is applied first. The operand seen by use_acc is 0, and acc <= the resulting value.
  - acc_clr with no accept while backpressured: acc clears, and the held output is unaffected.
- Flags are computed from the registered result value. They are registered alongside it, not from the live inputs.
- in_op, in_a, in_b and use_acc are sampled only on accept. Changes while in_ready=0 have no effect.
- Reset mid-operation: a held result is discarded, out_valid drops asynchronously, and acc is zeroed. The first accept after reset uses acc=0.
- WIDTH=1: out_ones == out_parity == out_result, and out_zero == !out_result.

Decomposition:
- Shared ALU package holds:
  - the opcode enumeration (3-bit, values above) used by the ALU top-level decoder;
  - the opcode width constant LU_OP_W=3.
- One natural sub-module: logic_unit_core, the purely combinational opcode mux (A, B, op -> result) parametrised by WIDTH. It is reusable by the ALU's unregistered path.
- Handshake, accumulator and flag registers stay in logic_unit_pipe.

Test Plan:
- WIDTH=4, out_ready=1: accept A=1100, B=1010, op=AND -> next cycle out_valid=1, out_result=1000, zero=0, ones=0, parity=1. Sweep ops 1..7 on the same operands -> 1110, 0110, 0111, 0001, 1001, 0100, 1100.
- Back-to-back 3 transactions with out_ready=1 -> three consecutive out_valid cycles, results in order, in_ready never low.
- Backpressure: out_ready=0 after the first accept; in_valid held with new operands -> in_ready=0, out_result is stable for 4 cycles. Raise out_ready -> the second result appears the next cycle, with no loss or duplication.
- Accumulate: op=OR, use_acc=1, A=0011 -> result 0011, acc_q=0011. Then A=0100 -> 0111. Then op=AND, A=0101 -> 0101.
- acc_clr asserted together with an accept of op=OR, use_acc=1, A=1000 while acc=0111 -> result 1000 and acc_q=1000. acc_clr alone -> acc_q=0, with the output register untouched.
- Assert rst_n=0 mid-stall with out_valid=1, acc=1111 -> out_valid and all flags 0, and acc_q=0 immediately (async). After release, op=XNOR, A=B=0000 -> 1111 with ones=1 and parity=0. Repeat at WIDTH=1 and WIDTH=16.
